jtframe_sdram_arb: RTL and testbench
====================================

Name: jtframe_sdram_arb

Overview:
Round-robin arbiter that shares the single SDRAM controller port (sdram_req/ack, data_read/data_rdy, write-back) between SLOTS game-side requesters. Sits between the game's ROM/RAM slot logic and the board SDRAM controller, on the SDRAM clock domain. It latches one request at a time, sequences the controller handshake, and routes returned data to the winning slot. A watchdog recovers from lost data_rdy.

Parameters:
SLOTS, 4, number of requesters (2..8)
AW, 22, SDRAM word address width
TOUT, 255, cycles allowed in WAIT before abort (8-bit counter)

Ports:
clk_rom  in  1  SDRAM-domain clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
loop_rst  in  1  controller init in progress; synchronous abort to IDLE
slot_req  in  SLOTS  per-slot request level, held until slot_ok
slot_addr  in  SLOTS*AW  packed addresses, slot i at [i*AW +: AW]
slot_rnw  in  SLOTS  1=read, 0=write
slot_wrmask  in  SLOTS*2  packed byte masks, active low
slot_din  in  SLOTS*16  packed write data
slot_ok  out  SLOTS  one-cycle completion pulse, one-hot
slot_dout  out  32  read data for the slot flagged by slot_ok
sdram_req  out  1  request to controller
sdram_ack  in  1  controller accepted the request
sdram_addr  out  AW  latched address
sdram_rnw  out  1  latched direction
sdram_wrmask  out  2  latched mask
data_write  out  16  latched write data
data_read  in  32  controller read data
data_rdy  in  1  controller data/write-done strobe
refresh_en  out  1  controller may refresh
timeout_err  out  1  sticky: a transaction was aborted by the watchdog

Behaviour:
- Reset (rst_n=0, async): state IDLE, sdram_req=0, sdram_addr=0, sdram_rnw=1, sdram_wrmask=2'b11, data_write=0, slot_ok=0, slot_dout=0, timeout_err=0, priority pointer=0, watchdog=0.
- States: IDLE, REQ, WAIT.
- IDLE: if any slot_req, choose the first set bit scanning from the pointer upward, wrapping modulo SLOTS. Latch its addr/rnw/wrmask/din into the sdram_* outputs and the grant index. Next cycle: REQ with sdram_req=1. No request: stay.
- REQ: sdram_req held 1 with outputs stable until sdram_ack=1. On the ack edge: sdram_req=0, watchdog cleared, go WAIT.
- WAIT: watchdog increments each cycle.
  - data_rdy=1: next cycle slot_ok[grant]=1 for exactly one cycle; slot_dout=data_read (captured also for writes); pointer=(grant+1) mod SLOTS; go IDLE.
  - watchdog reaches TOUT without data_rdy: go IDLE, set timeout_err, no slot_ok, pointer advances as for completion.
- ack and data_rdy in the same REQ cycle: treated as completion, going straight to IDLE with slot_ok.
- Min turnaround: a new grant may be latched in the IDLE cycle that coincides with slot_ok. A slot must drop slot_req on slot_ok or it is re-arbitrated (fairness via pointer).
- A slot dropping slot_req mid-transaction does not abort; the transaction completes and slot_ok still pulses.
- slot_req inputs are sampled only in IDLE; changes during REQ/WAIT have no effect.
- refresh_en=1 only in IDLE with slot_req==0 (combinational from state and slot_req).
- loop_rst=1 (sync): state IDLE, sdram_req=0, slot_ok=0, watchdog=0; pointer and timeout_err kept. No slot_ok for the killed transaction. While loop_rst=1, no grant is issued.
- timeout_err clears only on rst_n.
- Width rules: pointer/grant are $clog2(SLOTS) bits; pointer wrap uses explicit modulo for non-power-of-2 SLOTS.

Test Plan:
- Single read: slot2 req addr 22'h01234, ack 3 cycles later, data_rdy 5 later with data_read=32'hDEADBEEF -> sdram_req 1 cycle after req for exactly 3 cycles; slot_ok=4'b0100 one cycle after data_rdy; slot_dout=32'hDEADBEEF.
- Round robin: all 4 slots request continuously, controller ack/rdy immediately -> grant order 0,1,2,3,0; no slot is granted twice before all others are served.
- Write: slot1 rnw=0, wrmask=2'b10, din=16'hA55A -> sdram_rnw=0, sdram_wrmask=2'b10, data_write=16'hA55A stable from req through ack; slot_ok[1] on data_rdy.
- Watchdog: ack but never data_rdy -> after 255 WAIT cycles state IDLE, timeout_err=1, slot_ok never pulses, next pending slot granted.
- loop_rst mid-WAIT: assert for 2 cycles -> sdram_req=0, no slot_ok; after release the held slot_req is re-granted and completes.
- Async reset mid-REQ: rst_n low between edges -> sdram_req drops immediately; all outputs at reset values.

Source files
------------

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter that shares one SDRAM controller port among SLOTS requesters.
// One transaction is in flight at a time; a watchdog aborts a WAIT that never sees data_rdy.
module jtframe_sdram_arb #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int TOUT  = 255
) (
    input  logic                clk_rom,
    input  logic                rst_n,
    input  logic                loop_rst,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    input  logic [SLOTS-1:0]    slot_rnw,
    input  logic [SLOTS*2-1:0]  slot_wrmask,
    input  logic [SLOTS*16-1:0] slot_din,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [31:0]         slot_dout,
    output logic                sdram_req,
    input  logic                sdram_ack,
    output logic [AW-1:0]       sdram_addr,
    output logic                sdram_rnw,
    output logic [1:0]          sdram_wrmask,
    output logic [15:0]         data_write,
    input  logic [31:0]         data_read,
    input  logic                data_rdy,
    output logic                refresh_en,
    output logic                timeout_err
);
    localparam int PW = $clog2(SLOTS);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, gnt_q, gnt_d;
    logic [PW-1:0]   pick, nxt_ptr;
    logic            hit, done;
    int              idx;
    logic [7:0]      wdog_q, wdog_d, wdog_inc;
    logic            req_q, req_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            rnw_q, rnw_d;
    logic [1:0]      mask_q, mask_d;
    logic [15:0]     dw_q, dw_d;
    logic [SLOTS-1:0] ok_q, ok_d;
    logic [31:0]     dout_q, dout_d;
    logic            terr_q, terr_d;

    // First requester at or after the pointer, wrapping modulo SLOTS
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        idx  = 0;
        for (int i = 0; i < SLOTS; i++) begin
            idx = (int'(ptr_q) + i) % SLOTS;
            if (!hit && slot_req[idx]) begin
                hit  = 1'b1;
                pick = PW'(idx);
            end
        end
    end

    assign nxt_ptr  = PW'((int'(gnt_q) + 1) % SLOTS);
    assign wdog_inc = wdog_q + 8'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        wdog_d  = wdog_q;
        req_d   = req_q;
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        mask_d  = mask_q;
        dw_d    = dw_q;
        ok_d    = '0;
        dout_d  = dout_q;
        terr_d  = terr_q;
        done    = 1'b0;
        if (loop_rst) begin
            state_d = IDLE;
            req_d   = 1'b0;
            wdog_d  = '0;
        end else begin
            case (state_q)
                IDLE: if (hit) begin
                    gnt_d   = pick;
                    addr_d  = slot_addr[int'(pick)*AW +: AW];
                    rnw_d   = slot_rnw[pick];
                    mask_d  = slot_wrmask[int'(pick)*2 +: 2];
                    dw_d    = slot_din[int'(pick)*16 +: 16];
                    req_d   = 1'b1;
                    state_d = REQ;
                end
                REQ: if (sdram_ack) begin
                    req_d  = 1'b0;
                    wdog_d = '0;
                    if (data_rdy) done = 1'b1;
                    else          state_d = WAIT;
                end
                WAIT: if (data_rdy) begin
                    done = 1'b1;
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == 8'(TOUT)) begin
                        state_d = IDLE;
                        terr_d  = 1'b1;
                        ptr_d   = nxt_ptr;
                    end
                end
                default: state_d = IDLE;
            endcase
            // Write completions also capture data_read so slot_dout is always the last strobe
            if (done) begin
                ok_d    = SLOTS'(1) << gnt_q;
                dout_d  = data_read;
                ptr_d   = nxt_ptr;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            wdog_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            rnw_q   <= 1'b1;
            mask_q  <= 2'b11;
            dw_q    <= '0;
            ok_q    <= '0;
            dout_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            wdog_q  <= wdog_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            mask_q  <= mask_d;
            dw_q    <= dw_d;
            ok_q    <= ok_d;
            dout_q  <= dout_d;
            terr_q  <= terr_d;
        end
    end

    assign sdram_req    = req_q;
    assign sdram_addr   = addr_q;
    assign sdram_rnw    = rnw_q;
    assign sdram_wrmask = mask_q;
    assign data_write   = dw_q;
    assign slot_ok      = ok_q;
    assign slot_dout    = dout_q;
    assign timeout_err  = terr_q;
    assign refresh_en   = (state_q == IDLE) && (slot_req == '0);

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Bench for jtframe_sdram_arb: directed scenarios with literal expectations plus a
// randomized run, all continuously checked against a transaction-level model.
module tb_jtframe_sdram_arb;
    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int TOUT  = 255;

    logic                clk_rom = 1'b0;
    logic                rst_n = 1'b0;
    logic                loop_rst = 1'b0;
    logic [SLOTS-1:0]    slot_req = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS-1:0]    slot_rnw = '1;
    logic [SLOTS*2-1:0]  slot_wrmask = '1;
    logic [SLOTS*16-1:0] slot_din = '0;
    logic [SLOTS-1:0]    slot_ok;
    logic [31:0]         slot_dout;
    logic                sdram_req;
    logic                sdram_ack = 1'b0;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_rnw;
    logic [1:0]          sdram_wrmask;
    logic [15:0]         data_write;
    logic [31:0]         data_read = '0;
    logic                data_rdy = 1'b0;
    logic                refresh_en;
    logic                timeout_err;

    jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .TOUT(TOUT)) dut (
        .clk_rom(clk_rom), .rst_n(rst_n), .loop_rst(loop_rst),
        .slot_req(slot_req), .slot_addr(slot_addr), .slot_rnw(slot_rnw),
        .slot_wrmask(slot_wrmask), .slot_din(slot_din),
        .slot_ok(slot_ok), .slot_dout(slot_dout),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
        .sdram_rnw(sdram_rnw), .sdram_wrmask(sdram_wrmask), .data_write(data_write),
        .data_read(data_read), .data_rdy(data_rdy),
        .refresh_en(refresh_en), .timeout_err(timeout_err)
    );

    always #5 clk_rom = ~clk_rom;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase 0: free, 1: request posted to controller, 2: waiting for data
    int               m_phase, m_gnt, m_ptr, m_wd, m_pick, m_next;
    logic             m_req, m_rnw, m_terr;
    logic [AW-1:0]    m_addr;
    logic [1:0]       m_mask;
    logic [15:0]      m_dw;
    logic [SLOTS-1:0] m_ok;
    logic [31:0]      m_dout;

    // Winner = requesting slot with the smallest forward distance from the pointer
    function automatic int rr_pick(input logic [SLOTS-1:0] rq, input int ptr);
        int best, bd, d;
        best = -1;
        bd   = SLOTS;
        for (int i = 0; i < SLOTS; i++) begin
            d = (i - ptr + SLOTS) % SLOTS;
            if (rq[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    always_comb m_pick = rr_pick(slot_req, m_ptr);
    always_comb m_next = (m_gnt + 1) % SLOTS;

    always @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_gnt <= 0; m_ptr <= 0; m_wd <= 0;
            m_req <= 1'b0; m_rnw <= 1'b1; m_terr <= 1'b0;
            m_addr <= '0; m_mask <= 2'b11; m_dw <= '0; m_ok <= '0; m_dout <= '0;
        end else begin
            m_ok <= '0;
            if (loop_rst) begin
                m_phase <= 0; m_req <= 1'b0; m_wd <= 0;
            end else if (m_phase == 0) begin
                if (m_pick >= 0) begin
                    m_gnt   <= m_pick;
                    m_addr  <= slot_addr[m_pick*AW +: AW];
                    m_rnw   <= slot_rnw[m_pick];
                    m_mask  <= slot_wrmask[m_pick*2 +: 2];
                    m_dw    <= slot_din[m_pick*16 +: 16];
                    m_req   <= 1'b1;
                    m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                if (sdram_ack) begin
                    m_req <= 1'b0;
                    m_wd  <= 0;
                    if (data_rdy) begin
                        m_ok[m_gnt] <= 1'b1; m_dout <= data_read; m_ptr <= m_next; m_phase <= 0;
                    end else begin
                        m_phase <= 2;
                    end
                end
            end else begin
                if (data_rdy) begin
                    m_ok[m_gnt] <= 1'b1; m_dout <= data_read; m_ptr <= m_next; m_phase <= 0;
                end else if (m_wd + 1 >= TOUT) begin
                    m_phase <= 0; m_terr <= 1'b1; m_ptr <= m_next;
                end else begin
                    m_wd <= m_wd + 1;
                end
            end
        end
    end

    always @(posedge clk_rom) begin
        #1;
        if (rst_n) begin
            chk("sdram_req",    32'(sdram_req),    32'(m_req));
            chk("sdram_addr",   32'(sdram_addr),   32'(m_addr));
            chk("sdram_rnw",    32'(sdram_rnw),    32'(m_rnw));
            chk("sdram_wrmask", 32'(sdram_wrmask), 32'(m_mask));
            chk("data_write",   32'(data_write),   32'(m_dw));
            chk("slot_ok",      32'(slot_ok),      32'(m_ok));
            chk("slot_dout",    slot_dout,         m_dout);
            chk("timeout_err",  32'(timeout_err),  32'(m_terr));
            chk("refresh_en",   32'(refresh_en),   32'((m_phase == 0) && (slot_req == '0)));
        end
    end

    // ---------------- controller / slot stimulus ----------------
    int          ack_dly = 0, rdy_dly = 0, ack_wait = 0, rdy_cnt = 0;
    bit          pend = 0, rdy_never = 0, rnd = 0, auto_drop = 0, rd_fix = 0;
    logic [31:0] rd_val = '0;

    task automatic cyc();
        @(negedge clk_rom);
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        if (auto_drop) slot_req = slot_req & ~slot_ok;
        if (loop_rst) pend = 0;
        if (pend) begin
            if (rdy_cnt <= 1) begin
                data_rdy  = 1'b1;
                data_read = rd_fix ? rd_val : $urandom;
                pend      = 0;
            end else begin
                rdy_cnt--;
            end
        end
        if (sdram_req) begin
            if (ack_wait >= ack_dly) begin
                sdram_ack = 1'b1;
                ack_wait  = 0;
                if (rnd) begin
                    rdy_dly   = $urandom_range(0, 8);
                    rdy_never = ($urandom_range(0, 59) == 0);
                end
                if (!rdy_never) begin
                    if (rdy_dly == 0) begin
                        data_rdy  = 1'b1;
                        data_read = rd_fix ? rd_val : $urandom;
                    end else begin
                        pend    = 1;
                        rdy_cnt = rdy_dly;
                    end
                end
            end else begin
                ack_wait++;
            end
        end else begin
            ack_wait = 0;
            if (rnd) ack_dly = $urandom_range(0, 3);
        end
        if (rnd) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (!slot_req[i] && $urandom_range(0, 5) == 0) begin
                    slot_req[i]            = 1'b1;
                    slot_addr[i*AW +: AW]  = AW'($urandom);
                    slot_rnw[i]            = 1'($urandom);
                    slot_wrmask[i*2 +: 2]  = 2'($urandom);
                    slot_din[i*16 +: 16]   = 16'($urandom);
                end else if (slot_req[i] && $urandom_range(0, 39) == 0) begin
                    slot_addr[i*AW +: AW]  = AW'($urandom);
                    slot_din[i*16 +: 16]   = 16'($urandom);
                    slot_rnw[i]            = 1'($urandom);
                    slot_wrmask[i*2 +: 2]  = 2'($urandom);
                end else if (slot_req[i] && $urandom_range(0, 299) == 0) begin
                    slot_req[i] = 1'b0;
                end
            end
            if (loop_rst) loop_rst = 1'($urandom_range(0, 1));
            else          loop_rst = ($urandom_range(0, 249) == 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    int               order[5];
    int               n, first, reqn, rdyc, okc, okn, ackc, terrc, grants;
    logic [SLOTS-1:0] okv;
    logic [31:0]      dv;
    logic [AW-1:0]    gaddr;
    logic             stable, prev;

    initial begin
        // reset values
        repeat (3) @(negedge clk_rom);
        chk("rst sdram_req",    32'(sdram_req),    32'h0);
        chk("rst sdram_addr",   32'(sdram_addr),   32'h0);
        chk("rst sdram_rnw",    32'(sdram_rnw),    32'h1);
        chk("rst sdram_wrmask", 32'(sdram_wrmask), 32'h3);
        chk("rst data_write",   32'(data_write),   32'h0);
        chk("rst slot_ok",      32'(slot_ok),      32'h0);
        chk("rst slot_dout",    slot_dout,         32'h0);
        chk("rst timeout_err",  32'(timeout_err),  32'h0);
        chk("rst refresh_en",   32'(refresh_en),   32'h1);
        rst_n = 1'b1;

        // round robin, all slots requesting, controller answers at once
        for (int i = 0; i < SLOTS; i++) slot_addr[i*AW +: AW] = AW'(32'h100 + i);
        slot_req = '1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            cyc();
            if (sdram_req) begin
                order[n] = int'(sdram_addr) - 32'h100;
                n++;
            end
        end
        chk("rr grants", 32'(n), 32'd5);
        chk("rr g0", 32'(order[0]), 32'd0);
        chk("rr g1", 32'(order[1]), 32'd1);
        chk("rr g2", 32'(order[2]), 32'd2);
        chk("rr g3", 32'(order[3]), 32'd3);
        chk("rr g4", 32'(order[4]), 32'd0);
        slot_req = '0;
        repeat (4) cyc();

        // single read on slot 2
        ack_dly = 2; rdy_dly = 5; auto_drop = 1; rd_fix = 1; rd_val = 32'hDEADBEEF;
        slot_addr[2*AW +: AW] = 22'h01234;
        slot_rnw[2] = 1'b1;
        slot_req[2] = 1'b1;
        first = -1; reqn = 0; rdyc = -1; okc = -1; okn = 0; okv = '0; dv = '0;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            if (sdram_req) begin reqn++; if (first < 0) first = c; end
            if (data_rdy) rdyc = c;
            if (slot_ok != '0) begin okn++; okc = c; okv = slot_ok; dv = slot_dout; end
        end
        chk("rd req start", 32'(first), 32'd1);
        chk("rd req len",   32'(reqn),  32'd3);
        chk("rd rdy cyc",   32'(rdyc),  32'd8);
        chk("rd ok cyc",    32'(okc),   32'd9);
        chk("rd ok count",  32'(okn),   32'd1);
        chk("rd ok vec",    32'(okv),   32'b0100);
        chk("rd dout",      dv,         32'hDEADBEEF);

        // write on slot 1; slot data changes after grant must not leak through
        ack_dly = 3; rdy_dly = 2;
        slot_addr[1*AW +: AW] = 22'h2A5A5;
        slot_rnw[1] = 1'b0;
        slot_wrmask[2 +: 2] = 2'b10;
        slot_din[16 +: 16] = 16'hA55A;
        slot_req[1] = 1'b1;
        reqn = 0; okv = '0; stable = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            if (c == 2) begin slot_din[16 +: 16] = 16'h0000; slot_wrmask[2 +: 2] = 2'b01; end
            if (sdram_req) begin
                reqn++;
                if (sdram_rnw !== 1'b0 || sdram_wrmask !== 2'b10 || data_write !== 16'hA55A) stable = 1'b0;
            end
            if (slot_ok != '0) okv = slot_ok;
        end
        chk("wr req len", 32'(reqn),   32'd4);
        chk("wr stable",  32'(stable), 32'd1);
        chk("wr ok vec",  32'(okv),    32'b0010);
        slot_rnw[1] = 1'b1;

        // watchdog: slot 0 acked but never completes, slot 3 pending behind it
        ack_dly = 1; rdy_never = 1;
        slot_addr[0*AW +: AW] = 22'h3AAAA;
        slot_addr[3*AW +: AW] = 22'h2BBBB;
        slot_rnw[3] = 1'b1;
        slot_req[0] = 1'b1;
        ackc = -1; terrc = -1; okn = 0; gaddr = '0;
        for (int c = 1; c <= 400; c++) begin
            cyc();
            if (sdram_ack && ackc < 0) begin ackc = c; slot_req[3] = 1'b1; end
            if (slot_ok != '0) okn++;
            if (terrc >= 0 && sdram_req) begin gaddr = sdram_addr; break; end
            if (timeout_err && terrc < 0) begin
                terrc = c; slot_req[0] = 1'b0; rdy_never = 0; rdy_dly = 2;
            end
        end
        chk("wd wait len", 32'(terrc - ackc), 32'd256);
        chk("wd no ok",    32'(okn),          32'd0);
        chk("wd next gnt", 32'(gaddr),        32'h2BBBB);
        okv = '0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (slot_ok != '0) okv = slot_ok;
        end
        chk("wd next ok",  32'(okv),         32'b1000);
        chk("wd sticky",   32'(timeout_err), 32'd1);

        // loop_rst mid-WAIT on slot 2, then re-grant and complete
        ack_dly = 1; rdy_dly = 30;
        slot_addr[2*AW +: AW] = 22'h0F0F0;
        slot_req[2] = 1'b1;
        ackc = -1;
        for (int c = 1; c <= 10 && ackc < 0; c++) begin
            cyc();
            if (sdram_ack) ackc = c;
        end
        chk("lr acked", 32'(ackc >= 0), 32'd1);
        repeat (3) cyc();
        loop_rst = 1'b1;
        cyc();
        chk("lr req0 a", 32'(sdram_req), 32'd0);
        chk("lr ok0 a",  32'(slot_ok),   32'd0);
        cyc();
        chk("lr req0 b", 32'(sdram_req), 32'd0);
        loop_rst = 1'b0;
        rdy_dly = 3;
        grants = 0; okn = 0; okv = '0; prev = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            if (sdram_req && !prev) grants++;
            prev = sdram_req;
            if (slot_ok != '0) begin okn++; okv = slot_ok; end
        end
        chk("lr regrant", 32'(grants), 32'd1);
        chk("lr ok cnt",  32'(okn),    32'd1);
        chk("lr ok vec",  32'(okv),    32'b0100);

        // randomized traffic
        rd_fix = 0; rnd = 1;
        repeat (3000) cyc();
        rnd = 0; loop_rst = 1'b0; slot_req = '0; rdy_never = 0; ack_dly = 1; rdy_dly = 2;
        repeat (300) cyc();

        // asynchronous reset while a request is posted
        ack_dly = 5;
        slot_addr[1*AW +: AW] = 22'h15555;
        slot_req[1] = 1'b1;
        first = -1;
        for (int c = 1; c <= 10 && first < 0; c++) begin
            cyc();
            if (sdram_req) first = c;
        end
        chk("ar in req", 32'(first >= 0), 32'd1);
        @(posedge clk_rom);
        #3 rst_n = 1'b0;
        #1;
        chk("ar sdram_req",    32'(sdram_req),    32'h0);
        chk("ar sdram_addr",   32'(sdram_addr),   32'h0);
        chk("ar sdram_rnw",    32'(sdram_rnw),    32'h1);
        chk("ar sdram_wrmask", 32'(sdram_wrmask), 32'h3);
        chk("ar data_write",   32'(data_write),   32'h0);
        chk("ar slot_ok",      32'(slot_ok),      32'h0);
        chk("ar slot_dout",    slot_dout,         32'h0);
        chk("ar timeout_err",  32'(timeout_err),  32'h0);
        slot_req = '0;
        cyc();
        rst_n = 1'b1;
        repeat (5) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
